// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I access-size codes,
// FSM states and the alignment rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_e;

  // Byte accesses can never be misaligned; halfwords need off[0]=0, words off=0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_format.sv
// Extracts and extends a byte/halfword/word from a 32-bit read word.
// Purely combinational so a future cache can reuse it on its own data path.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into a word-addressed
// req/ready/rvalid data-memory transaction and stalls the pipeline while it is in flight.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_stall,
  output logic              mem_err
);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              access;
  logic              is_load;
  logic              funct3_ok;
  logic              legal;
  logic [1:0]        off;
  logic [3:0]        store_be;
  logic [DATA_W-1:0] store_wdata;
  logic [DATA_W-1:0] load_result;

  assign access  = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign is_load = ex_mem_rd;
  assign off     = ex_addr[1:0];
  assign legal   = funct3_ok & ~is_misaligned(ex_funct3, off);

  always_comb begin
    funct3_ok   = 1'b0;
    store_be    = 4'b1111;
    store_wdata = ex_wdata;
    case (ex_funct3)
      F3_B: begin
        funct3_ok   = 1'b1;
        store_be    = 4'b0001 << off;
        store_wdata = {4{ex_wdata[7:0]}};
      end
      F3_H: begin
        funct3_ok   = 1'b1;
        store_be    = 4'b0011 << off;
        store_wdata = {2{ex_wdata[15:0]}};
      end
      F3_W:         funct3_ok = 1'b1;
      F3_BU, F3_HU: funct3_ok = is_load;
      default:      funct3_ok = 1'b0;
    endcase
  end

  // Offset and size are captured with the request so formatting does not depend on EX/MEM.
  lsu_load_format u_load_format (
    .rdata  (dmem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    off_d     = off_q;
    funct3_d  = funct3_q;
    data_d    = data_q;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && legal) begin
          mem_stall = 1'b1;
          req_d     = 1'b1;
          we_d      = ~is_load;
          addr_d    = {ex_addr[ADDR_W-1:2], 2'b00};
          wdata_d   = store_wdata;
          be_d      = is_load ? 4'b1111 : store_be;
          off_d     = off;
          funct3_d  = ex_funct3;
          state_d   = REQ;
        end else if (access) begin
          mem_err = 1'b1;
          data_d  = '0;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem_ready) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : RESP;
        end
      end
      RESP: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          data_d  = load_result;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      data_q   <= data_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign mem_data_out = mem_err ? '0 : data_q;

endmodule
